// File: rtl/top_level.sv
// CSE141L program-3 engine: counts 5-bit pattern hits in a 32-byte message held in
// data memory dm1 and writes the three counts back to dm1[33..35].

module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr_a,
  output logic [7:0] rd_data_a,
  input  logic [7:0] rd_addr_b,
  output logic [7:0] rd_data_b
);
  // No reset on the array: the message is preloaded before the program starts.
  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we) begin
      core[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = core[rd_addr_a];
  assign rd_data_b = core[rd_addr_b];
endmodule

module top_level #(
  parameter int progID = 3
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  // done is a level acknowledge: a one-cycle reset pulse requests a run, done
  // stays high from completion until the next reset.
  localparam bit PROG_SEL = (progID == 3);

  typedef enum logic [2:0] {
    SCAN = 3'd0,
    WR33 = 3'd1,
    WR34 = 3'd2,
    WR35 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic [7:0]  prev_byte;
  logic [7:0]  ctb;
  logic [7:0]  cto;
  logic [7:0]  cts;

  logic [7:0]  cur_byte;
  logic [7:0]  pat_byte;
  logic [4:0]  pat;
  logic [11:0] window;
  logic [2:0]  within_hits;
  logic [2:0]  cross_hits;
  logic [3:0]  scan_hits;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        done_next;

  data_mem dm1 (
    .clk       (clk),
    .we        (mem_we),
    .wr_addr   (mem_addr),
    .wr_data   (mem_data),
    .rd_addr_a ({3'd0, idx}),
    .rd_data_a (cur_byte),
    .rd_addr_b (8'd32),
    .rd_data_b (pat_byte)
  );

  assign pat = pat_byte[7:3];

  // Windows at bit offsets 4..7 of {prev[3:0], cur} straddle the byte boundary.
  always_comb begin
    within_hits = 3'd0;
    cross_hits  = 3'd0;
    window      = {prev_byte[3:0], cur_byte};
    for (int k = 0; k < 4; k++) begin
      if (cur_byte[k +: 5] == pat) begin
        within_hits = within_hits + 3'd1;
      end
    end
    if (idx != 5'd0) begin
      for (int k = 4; k < 8; k++) begin
        if (window[k +: 5] == pat) begin
          cross_hits = cross_hits + 3'd1;
        end
      end
    end
    scan_hits = {1'b0, within_hits} + {1'b0, cross_hits};
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = 8'd0;
    mem_data   = 8'd0;
    done_next  = 1'b1;
    if (PROG_SEL) begin
      done_next = (state == DONE);
      case (state)
        SCAN: begin
          if (idx == 5'd31) begin
            state_next = WR33;
          end
        end
        WR33: begin
          mem_we     = 1'b1;
          mem_addr   = 8'd33;
          mem_data   = ctb;
          state_next = WR34;
        end
        WR34: begin
          mem_we     = 1'b1;
          mem_addr   = 8'd34;
          mem_data   = cto;
          state_next = WR35;
        end
        WR35: begin
          mem_we     = 1'b1;
          mem_addr   = 8'd35;
          mem_data   = cts;
          state_next = DONE;
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = SCAN;
        end
      endcase
      // A reset arriving during a write cycle aborts that write.
      if (reset) begin
        mem_we = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      idx       <= 5'd0;
      prev_byte <= 8'd0;
      ctb       <= 8'd0;
      cto       <= 8'd0;
      cts       <= 8'd0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (PROG_SEL && state == SCAN) begin
        idx       <= idx + 5'd1;
        prev_byte <= cur_byte;
        ctb       <= ctb + {5'd0, within_hits};
        cts       <= cts + {4'd0, scan_hits};
        if (within_hits != 3'd0) begin
          cto <= cto + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed vector table, random messages against
// a bit-string model, mid-scan reset and a progID=5 instance.

module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;
  logic done_p5;

  always #5 clk = ~clk;

  top_level DUT (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  top_level #(.progID(5)) u_p5 (
    .clk   (clk),
    .reset (reset),
    .done  (done_p5)
  );

  typedef struct {
    logic [4:0] pat;
    logic [7:0] b0;
    logic [7:0] fill;
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;
  } vec_t;

  vec_t       vecs [8];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] msg [32];
  logic [7:0] pat_byte;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the message as one 256-bit string, core[0] most significant.
  task automatic model(output logic [7:0] e_ctb, output logic [7:0] e_cto, output logic [7:0] e_cts);
    logic [255:0] s;
    logic [4:0]   p;
    int           n_b;
    int           n_o;
    int           n_s;
    int           hit;
    p   = pat_byte[7:3];
    n_b = 0;
    n_o = 0;
    n_s = 0;
    for (int j = 0; j < 32; j++) begin
      s[255 - 8 * j -: 8] = msg[j];
      hit = 0;
      for (int k = 0; k < 4; k++) begin
        if (msg[j][k +: 5] == p) hit++;
      end
      n_b += hit;
      if (hit != 0) n_o++;
    end
    for (int q = 0; q < 252; q++) begin
      if (s[255 - q -: 5] == p) n_s++;
    end
    e_ctb = 8'(n_b);
    e_cto = 8'(n_o);
    e_cts = 8'(n_s);
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic reset_and_load(input bit load);
    @(negedge clk);
    reset = 1'b1;
    if (load) begin
      for (int i = 0; i < 32; i++) DUT.dm1.core[i] = msg[i];
      DUT.dm1.core[32] = pat_byte;
    end
    @(negedge clk);
    reset = 1'b0;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_done_p5", {31'd0, done_p5}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_p5_done"}, {31'd0, done_p5}, 32'd1);
    end
    check({tag, "_latency"}, 32'(n), 32'd36);
  endtask

  task automatic check_results(input string tag);
    logic [7:0] e;
    int         diffs;
    for (int a = 33; a < 36; a++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_core%0d", tag, a), {24'd0, DUT.dm1.core[a]}, {24'd0, e});
    end
    diffs = 0;
    for (int i = 0; i < 32; i++) begin
      if (DUT.dm1.core[i] !== msg[i]) diffs++;
    end
    if (DUT.dm1.core[32] !== pat_byte) diffs++;
    check({tag, "_input_kept"}, 32'(diffs), 32'd0);
  endtask

  initial begin
    logic [7:0] a_ctb, a_cto, a_cts;
    logic [7:0] b_ctb, b_cto, b_cts;
    int         diffs;

    vecs[0] = '{5'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252};
    vecs[1] = '{5'h1F, 8'hFF, 8'hFF, 8'd128, 8'd32, 8'd252};
    vecs[2] = '{5'h15, 8'h55, 8'h55, 8'd64,  8'd32, 8'd126};
    vecs[3] = '{5'h02, 8'h01, 8'h00, 8'd0,   8'd0,  8'd1};
    vecs[4] = '{5'h01, 8'h01, 8'h00, 8'd1,   8'd1,  8'd1};
    vecs[5] = '{5'h10, 8'h80, 8'h80, 8'd32,  8'd32, 8'd32};
    vecs[6] = '{5'h01, 8'h01, 8'h01, 8'd32,  8'd32, 8'd32};
    vecs[7] = '{5'h00, 8'hFF, 8'hFF, 8'd0,   8'd0,  8'd0};

    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      DUT.dm1.core[i]   = 8'(i * 7);
      u_p5.dm1.core[i]  = 8'(i) ^ 8'h5A;
    end

    for (int v = 0; v < 8; v++) begin
      msg[0] = vecs[v].b0;
      for (int i = 1; i < 32; i++) msg[i] = vecs[v].fill;
      pat_byte = {vecs[v].pat, 3'b101};
      push_exp(vecs[v].ctb, vecs[v].cto, vecs[v].cts);
      reset_and_load(1'b1);
      wait_done($sformatf("vec%0d", v));
      check_results($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom_range(0, 255));
      pat_byte = 8'($urandom_range(0, 255));
      model(a_ctb, a_cto, a_cts);
      push_exp(a_ctb, a_cto, a_cts);
      reset_and_load(1'b1);
      wait_done($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r));
    end

    repeat (5) @(negedge clk);
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_hold_core35", {24'd0, DUT.dm1.core[35]}, {24'd0, a_cts});

    // Run A to completion, start B, abort B mid-scan and restart it.
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom_range(0, 255));
    pat_byte = 8'($urandom_range(0, 255));
    model(a_ctb, a_cto, a_cts);
    push_exp(a_ctb, a_cto, a_cts);
    reset_and_load(1'b1);
    wait_done("runa");
    check_results("runa");

    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom_range(0, 255));
    msg[5] = ~msg[5];
    pat_byte = 8'($urandom_range(0, 255));
    model(b_ctb, b_cto, b_cts);
    reset_and_load(1'b1);
    repeat (10) @(negedge clk);
    check("mid_done_low", {31'd0, done}, 32'd0);
    check("mid_core33_kept", {24'd0, DUT.dm1.core[33]}, {24'd0, a_ctb});
    check("mid_core34_kept", {24'd0, DUT.dm1.core[34]}, {24'd0, a_cto});
    push_exp(b_ctb, b_cto, b_cts);
    reset_and_load(1'b0);
    wait_done("runb");
    check_results("runb");

    diffs = 0;
    for (int i = 36; i < 256; i++) begin
      if (DUT.dm1.core[i] !== 8'(i * 7)) diffs++;
    end
    check("upper_mem_kept", 32'(diffs), 32'd0);
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (u_p5.dm1.core[i] !== (8'(i) ^ 8'h5A)) diffs++;
    end
    check("p5_mem_kept", 32'(diffs), 32'd0);
    check("p5_done_final", {31'd0, done_p5}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
